// File: rtl/product_accumulator.sv
// Sums COUNT unsigned 8-bit products per frame and hands the sum off through a ready/valid port.
// Optional macro ACC_SAT_EN makes the accumulator saturate on overflow instead of wrapping.
module product_accumulator #(
   parameter int ACC_W = 12,
   parameter int COUNT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       p_in,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             clear,
   output logic [ACC_W-1:0] sum_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             overflow
);

   // state | meaning
   // ACC   | accepting products into the running frame sum
   // OUT   | holding the completed sum until the consumer takes it
   typedef enum logic {ACC, OUT} state_t;

   localparam int          AW1  = ACC_W + 1;
   localparam logic [4:0]  LAST = 5'(COUNT - 1);

   state_t           state, state_nxt;
   logic [ACC_W-1:0] acc, acc_nxt, sum_q;
   logic [4:0]       cnt;
   logic             ovf;
   logic             accept, last, carry, handoff;
   logic [ACC_W:0]   add;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ACC;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      last      = 1'b0;
      handoff   = 1'b0;
      case (state)
         ACC: begin
            in_ready = 1'b1;
            accept   = in_valid;
            last     = in_valid && (cnt == LAST);
            if (last) state_nxt = OUT;
         end
         OUT: begin
            out_valid = 1'b1;
            handoff   = out_ready;
            if (out_ready) state_nxt = ACC;
         end
         default: state_nxt = ACC;
      endcase
      if (clear) state_nxt = ACC;
   end

   always_comb begin
      add   = {1'b0, acc} + AW1'(p_in);
      carry = add[ACC_W];
`ifdef ACC_SAT_EN
      acc_nxt = carry ? '1 : add[ACC_W-1:0];
`else
      acc_nxt = add[ACC_W-1:0];
`endif
   end

   // sum_out survives clear; it is only meaningful while out_valid is high
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc   <= '0;
         cnt   <= '0;
         ovf   <= 1'b0;
         sum_q <= '0;
      end else if (clear) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (accept) begin
         acc <= acc_nxt;
         ovf <= ovf | carry;
         if (last) begin
            cnt   <= '0;
            sum_q <= acc_nxt;
         end else begin
            cnt <= cnt + 5'd1;
         end
      end else if (handoff) begin
         acc <= '0;
         ovf <= 1'b0;
      end
   end

   assign sum_out  = sum_q;
   assign overflow = ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: default, narrow (ACC_W=9) and COUNT=1 instances.
module tb_product_accumulator;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   // instance 0: defaults
   logic [7:0]  p0 = '0;
   logic        v0 = 1'b0, clr0 = 1'b0, ordy0 = 1'b0;
   logic        ir0, ov0, of0;
   logic [11:0] s0;
   // instance 1: ACC_W=9
   logic [7:0]  p1 = '0;
   logic        v1 = 1'b0, clr1 = 1'b0, ordy1 = 1'b0;
   logic        ir1, ov1, of1;
   logic [8:0]  s1;
   // instance 2: COUNT=1
   logic [7:0]  p2 = '0;
   logic        v2 = 1'b0, clr2 = 1'b0, ordy2 = 1'b0;
   logic        ir2, ov2, of2;
   logic [11:0] s2;

   product_accumulator #(.ACC_W(12), .COUNT(4)) u0 (
      .clk(clk), .rst_n(rst_n), .p_in(p0), .in_valid(v0), .in_ready(ir0), .clear(clr0),
      .sum_out(s0), .out_valid(ov0), .out_ready(ordy0), .overflow(of0));
   product_accumulator #(.ACC_W(9), .COUNT(4)) u1 (
      .clk(clk), .rst_n(rst_n), .p_in(p1), .in_valid(v1), .in_ready(ir1), .clear(clr1),
      .sum_out(s1), .out_valid(ov1), .out_ready(ordy1), .overflow(of1));
   product_accumulator #(.ACC_W(12), .COUNT(1)) u2 (
      .clk(clk), .rst_n(rst_n), .p_in(p2), .in_valid(v2), .in_ready(ir2), .clear(clr2),
      .sum_out(s2), .out_valid(ov2), .out_ready(ordy2), .overflow(of2));

`ifdef ACC_SAT_EN
   localparam int OVF_SUM = 511;
`else
   localparam int OVF_SUM = 388;
`endif

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // one accepted beat on instance 0
   task automatic beat0(input int val);
      v0 = 1'b1;
      p0 = 8'(val);
      tick();
      v0 = 1'b0;
   endtask

   task automatic frame0(input int a, input int b, input int c, input int d);
      beat0(a); beat0(b); beat0(c); beat0(d);
   endtask

   initial begin
      // reset
      tick(); tick();
      chk("rst_sum", int'(s0), 0);
      chk("rst_out_valid", int'(ov0), 0);
      chk("rst_overflow", int'(of0), 0);
      chk("rst_in_ready", int'(ir0), 1);
      rst_n = 1'b1;
      tick();

      // basic frame
      ordy0 = 1'b1;
      beat0(28); beat0(30); beat0(50);
      chk("basic_early_valid", int'(ov0), 0);
      beat0(48);
      chk("basic_valid", int'(ov0), 1);
      chk("basic_sum", int'(s0), 156);
      chk("basic_ovf", int'(of0), 0);
      chk("basic_in_ready_out", int'(ir0), 0);
      tick();
      chk("basic_valid_1cyc", int'(ov0), 0);
      chk("basic_in_ready_back", int'(ir0), 1);

      // backpressure: offered beats in OUT must be ignored
      ordy0 = 1'b0;
      frame0(28, 30, 50, 48);
      v0 = 1'b1;
      p0 = 8'd99;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_valid", int'(ov0), 1);
         chk("bp_sum", int'(s0), 156);
         chk("bp_in_ready", int'(ir0), 0);
      end
      v0 = 1'b0;
      ordy0 = 1'b1;
      tick();
      chk("bp_release_valid", int'(ov0), 0);
      chk("bp_release_in_ready", int'(ir0), 1);
      frame0(1, 2, 3, 4);
      chk("bp_next_sum", int'(s0), 10);
      chk("bp_next_valid", int'(ov0), 1);
      tick();

      // clear mid-frame, with a beat offered in the clear cycle
      beat0(28); beat0(30);
      clr0 = 1'b1; v0 = 1'b1; p0 = 8'd50;
      tick();
      clr0 = 1'b0; v0 = 1'b0;
      chk("clr_no_valid", int'(ov0), 0);
      beat0(1); beat0(2); beat0(3);
      chk("clr_early_valid", int'(ov0), 0);
      beat0(4);
      chk("clr_sum", int'(s0), 10);
      chk("clr_valid", int'(ov0), 1);
      tick();

      // clear wins over a pending result
      ordy0 = 1'b0;
      frame0(5, 5, 5, 5);
      chk("clr_out_valid_pre", int'(ov0), 1);
      clr0 = 1'b1;
      tick();
      clr0 = 1'b0;
      chk("clr_out_drop", int'(ov0), 0);
      chk("clr_out_in_ready", int'(ir0), 1);
      ordy0 = 1'b1;
      frame0(10, 20, 30, 40);
      chk("clr_out_next_sum", int'(s0), 100);
      tick();

      // reset after 3 beats
      beat0(5); beat0(6); beat0(7);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("rstmid_sum", int'(s0), 0);
      chk("rstmid_valid", int'(ov0), 0);
      chk("rstmid_in_ready", int'(ir0), 1);
      frame0(1, 2, 3, 4);
      chk("rstmid_next_sum", int'(s0), 10);
      // reset while holding a result
      ordy0 = 1'b0;
      tick();
      chk("rstout_pre_valid", int'(ov0), 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("rstout_sum", int'(s0), 0);
      chk("rstout_valid", int'(ov0), 0);
      chk("rstout_in_ready", int'(ir0), 1);
      chk("rstout_ovf", int'(of0), 0);
      ordy0 = 1'b1;
      frame0(10, 20, 30, 40);
      chk("rstout_next_sum", int'(s0), 100);
      tick();

      // stalls between beats
      beat0(28); tick(); tick();
      beat0(30); beat0(50); tick();
      chk("stall_no_valid", int'(ov0), 0);
      chk("stall_in_ready", int'(ir0), 1);
      beat0(48);
      chk("stall_sum", int'(s0), 156);
      chk("stall_valid", int'(ov0), 1);
      tick();

      // overflow on ACC_W=9
      ordy1 = 1'b1;
      v1 = 1'b1; p1 = 8'd225;
      tick(); tick(); tick();
      chk("ovf_early_valid", int'(ov1), 0);
      tick();
      v1 = 1'b0;
      chk("ovf_valid", int'(ov1), 1);
      chk("ovf_flag", int'(of1), 1);
      chk("ovf_sum", int'(s1), OVF_SUM);
      tick();
      chk("ovf_flag_cleared", int'(of1), 0);
      chk("ovf_valid_drop", int'(ov1), 0);
      v1 = 1'b1;
      p1 = 8'd1; tick();
      p1 = 8'd2; tick();
      p1 = 8'd3; tick();
      p1 = 8'd4; tick();
      v1 = 1'b0;
      chk("ovf_next_sum", int'(s1), 10);
      chk("ovf_next_flag", int'(of1), 0);
      tick();

      // COUNT=1
      ordy2 = 1'b0;
      v2 = 1'b1; p2 = 8'd84;
      tick();
      chk("c1_valid", int'(ov2), 1);
      chk("c1_sum", int'(s2), 84);
      chk("c1_in_ready", int'(ir2), 0);
      p2 = 8'd7; ordy2 = 1'b1;
      tick();
      chk("c1_no_accept_in_out", int'(ov2), 0);
      chk("c1_in_ready_back", int'(ir2), 1);
      chk("c1_sum_hold", int'(s2), 84);
      tick();
      v2 = 1'b0;
      chk("c1_second_valid", int'(ov2), 1);
      chk("c1_second_sum", int'(s2), 7);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 The block SHALL have parameter ACC_W, default 12: accumulator and sum width in bits, legal range 8..16.
REQ-002 The block SHALL have parameter COUNT, default 4: number of products summed per result, legal range 1..16.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port p_in, input, 8 bits: unsigned product from the upstream 4-bit multiplier.
REQ-006 The block SHALL have port in_valid, input, 1 bit: p_in is valid this cycle.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts p_in this cycle.
REQ-008 The block SHALL have port clear, input, 1 bit: synchronous frame abort.
REQ-009 The block SHALL have port sum_out, output, ACC_W bits: completed frame sum.
REQ-010 The block SHALL have port out_valid, output, 1 bit: sum_out and overflow are valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the result.
REQ-012 The block SHALL have port overflow, output, 1 bit: the frame sum exceeded 2^ACC_W-1.

Function
REQ-013 The block SHALL implement a two-state FSM with states ACC and OUT; in_ready=1 only in ACC, and out_valid=1 only in OUT.
REQ-014 An input beat SHALL be accepted in any cycle where in_valid and in_ready are both 1; on acceptance acc <= acc + p_in, with p_in zero-extended, and beat counter cnt <= cnt+1.
REQ-015 On acceptance of beat number COUNT (cnt==COUNT-1), the FSM SHALL go to OUT, load sum_out with the final sum, and reset cnt to 0; out_valid SHALL rise on the next clock edge, giving 1-cycle latency from the last beat.
REQ-016 In OUT, sum_out and overflow SHALL be held stable until out_valid and out_ready are both 1; on that edge the FSM SHALL return to ACC with acc=0 and overflow=0.
REQ-017 When COUNT=1, every accepted beat SHALL produce a result; no beat SHALL be accepted while in OUT, even if out_ready is 1 in the same cycle.
REQ-018 Overflow SHALL be detected as a carry out of bit ACC_W-1 on any add in the frame; the flag SHALL be sticky for the frame.
REQ-019 clear=1 SHALL force, on the next edge, state ACC, acc=0, cnt=0, out_valid=0, overflow=0; clear SHALL take priority over input acceptance and the output handshake.
REQ-020 in_valid=0 cycles SHALL stall the frame with no change to acc or cnt.

Reset
REQ-021 With rst_n=0 at a clock edge, the block SHALL set state ACC, acc=0, cnt=0, sum_out=0, out_valid=0, overflow=0, in_ready=1 after the edge.
REQ-022 Reset SHALL take priority over clear and all handshakes, and SHALL discard any partial frame or pending result.

Configuration
REQ-023 With macro ACC_SAT_EN defined, an overflowing add SHALL saturate acc to 2^ACC_W-1 and hold it there for the rest of the frame.
REQ-024 Without ACC_SAT_EN, acc SHALL wrap modulo 2^ACC_W; in both builds the overflow flag SHALL behave per REQ-018.

Verification
REQ-025 Basic frame (defaults): beats 28,30,50,48 with out_ready=1 -> out_valid for 1 cycle, 1 cycle after beat 4, sum_out=156, overflow=0.
REQ-026 Backpressure: complete a frame with out_ready=0 for 3 cycles -> sum_out stays 156, in_ready=0, offered beats are not accepted; out_ready=1 -> in_ready=1 on the next cycle, next frame starts from 0.
REQ-027 Overflow (ACC_W=9): beats 225 x4 -> overflow=1; sum_out=511 with ACC_SAT_EN, 388 without.
REQ-028 Clear mid-frame: beats 28,30, then clear=1 -> no out_valid; the following beats 1,2,3,4 give sum_out=10.
REQ-029 Reset mid-operation: rst_n=0 for 1 cycle after 3 beats, and separately while in OUT -> all outputs at reset values; the next full frame sums correctly.
REQ-030 Stall and COUNT=1: in_valid gaps between beats do not change the result; with COUNT=1, beat 84 -> sum_out=84, and in_ready=0 during OUT.
